countgen_sequencer: RTL and testbench

Programmable period sequencer for a countgen square-wave generator. Holds a small table of (period, cycle-count) entries and plays it in order. For each entry it drives the generator's period input and reset, counts rising edges of the generator output, and advances once the programmed number of output cycles has elapsed. Sits between a register/config interface and one generator instance; supports one-shot and looping playback.

---
 rtl/countgen_sequencer_if.sv | 31 +++
 rtl/countgen_sequencer.sv | 115 +++++++++++
 tb/tb_countgen_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countgen_sequencer_if.sv
// Config, playback-control and generator-facing signals of the countgen sequencer.
// The master side is the config/control block plus the generator; the slave is the sequencer.
interface countgen_sequencer_if #(
  parameter int AW = 3,
  parameter int CW = 16
);
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [31:0]   cfg_period;
  logic [CW-1:0] cfg_count;
  logic [AW:0]   seq_len;
  logic          loop_en;
  logic          start;
  logic          stop;
  logic          gen_out;
  logic [31:0]   gen_period;
  logic          gen_rst;
  logic          busy;
  logic          done;
  logic [AW-1:0] cur_idx;

  modport master (
    output cfg_we, cfg_addr, cfg_period, cfg_count, seq_len, loop_en, start, stop, gen_out,
    input  gen_period, gen_rst, busy, done, cur_idx
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_period, cfg_count, seq_len, loop_en, start, stop, gen_out,
    output gen_period, gen_rst, busy, done, cur_idx
  );
endinterface

// File: rtl/countgen_sequencer.sv
// Plays a table of (period, cycle-count) entries into one countgen generator,
// counting gen_out rising edges to decide when each entry is finished.
//   state | meaning
//   IDLE  | generator held in reset, waiting for start
//   LOAD  | one cycle: new period presented, generator still in reset
//   RUN   | generator running, rising edges of gen_out counted
module countgen_sequencer #(
  parameter int AW = 3,
  parameter int CW = 16
) (
  input logic                clk,
  input logic                rst,
  countgen_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  localparam int            DEPTH   = 2 ** AW;
  localparam logic [AW:0]   MAX_LEN = (AW + 1)'(DEPTH);

  state_t        r_state, w_state_nxt;
  logic [31+CW:0] r_table [DEPTH];
  logic [31:0]   r_gen_period;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_edge_cnt;
  logic [AW-1:0] r_cur_idx, w_idx_nxt;
  logic [AW:0]   r_len;
  logic          r_loop;
  logic          r_gen_out_q;
  logic          r_done;
  logic          w_rise, w_entry_done, w_last, w_finish;
  logic [CW:0]   w_cnt_inc, w_target;

  always_ff @(posedge clk) begin
    if (bus.cfg_we) r_table[bus.cfg_addr] <= {bus.cfg_period, bus.cfg_count};
  end

  // Compare one bit wider than the counter so edge_cnt itself never has to wrap.
  assign w_rise       = bus.gen_out & ~r_gen_out_q;
  assign w_cnt_inc    = {1'b0, r_edge_cnt} + 1'b1;
  assign w_target     = (r_count == '0) ? (CW + 1)'(1) : {1'b0, r_count};
  assign w_entry_done = (r_state == RUN) && w_rise && (w_cnt_inc >= w_target);
  assign w_last       = ({1'b0, r_cur_idx} == (r_len - 1'b1));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_cur_idx;
    w_finish    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start && !bus.stop && (bus.seq_len != '0)) begin
          w_state_nxt = LOAD;
          w_idx_nxt   = '0;
        end
      end
      LOAD: w_state_nxt = bus.stop ? IDLE : RUN;
      RUN: begin
        if (bus.stop) begin
          w_state_nxt = IDLE;
        end else if (w_entry_done) begin
          if (!w_last) begin
            w_idx_nxt   = r_cur_idx + 1'b1;
            w_state_nxt = LOAD;
          end else if (r_loop) begin
            w_idx_nxt   = '0;
            w_state_nxt = LOAD;
          end else begin
            w_state_nxt = IDLE;
            w_finish    = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_gen_period <= '0;
      r_count      <= '0;
      r_edge_cnt   <= '0;
      r_cur_idx    <= '0;
      r_len        <= '0;
      r_loop       <= 1'b0;
      r_gen_out_q  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_idx <= w_idx_nxt;
      r_done    <= w_finish;
      if (r_state == IDLE && w_state_nxt == LOAD) begin
        r_len  <= (bus.seq_len > MAX_LEN) ? MAX_LEN : bus.seq_len;
        r_loop <= bus.loop_en;
      end
      // Entry fields are captured on the way into LOAD so later writes only affect future loads.
      if (w_state_nxt == LOAD) begin
        r_gen_period <= r_table[w_idx_nxt][CW +: 32];
        r_count      <= r_table[w_idx_nxt][CW-1:0];
      end
      if (r_state == RUN) begin
        r_gen_out_q <= bus.gen_out;
        if (w_rise && !w_entry_done) r_edge_cnt <= r_edge_cnt + 1'b1;
      end else begin
        r_gen_out_q <= 1'b0;
        r_edge_cnt  <= '0;
      end
    end
  end

  assign bus.gen_period = r_gen_period;
  assign bus.gen_rst    = (r_state != RUN);
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = r_done;
  assign bus.cur_idx    = r_cur_idx;
endmodule

// File: tb/tb_countgen_sequencer.sv
// Scoreboarded bench: a square-wave generator model drives gen_out, a monitor checks
// each entry load, its rising-edge count and run length, and every done pulse.
module tb_countgen_sequencer;
  localparam int AW    = 3;
  localparam int CW    = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  countgen_sequencer_if #(.AW(AW), .CW(CW)) bus ();
  countgen_sequencer #(.AW(AW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  int unsigned sh_period [DEPTH];
  int unsigned sh_count  [DEPTH];
  int  exp_idx_q [$];
  int  exp_done  = 0;
  bit  abort     = 1'b0;

  int  gcnt = 0;
  bit  gen_q = 1'b0;
  bit  in_run = 1'b0, after_load = 1'b0, prev_gen = 1'b0;
  int  edges = 0, run_cyc = 0, exp_edges = 0, exp_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic close_entry();
    if (abort) begin
      abort = 1'b0;
      exp_idx_q.delete();
    end else begin
      chk("entry_edges", edges, exp_edges);
      chk("entry_run_cycles", run_cyc, exp_cyc);
    end
  endtask

  // Generator model then monitor; gen_out set here is what the DUT samples next posedge.
  always @(negedge clk) begin : mon
    int p;
    int i;
    if (bus.gen_rst) begin
      gcnt  = 0;
      gen_q = 1'b0;
    end else begin
      gcnt++;
      p = (bus.gen_period == 0) ? 1 : int'(bus.gen_period);
      if (gcnt >= p) begin
        gcnt  = 0;
        gen_q = ~gen_q;
      end
    end
    bus.gen_out = gen_q;

    if (after_load && !abort) chk("one_cycle_gen_rst", bus.busy && !bus.gen_rst, 1);
    after_load = 1'b0;

    if (bus.busy && bus.gen_rst) begin
      if (in_run) close_entry();
      n_cmp++;
      if (exp_idx_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_load: cur_idx=%0d period=%0d with no entry expected",
                 bus.cur_idx, bus.gen_period);
        exp_edges = 0;
        exp_cyc   = 0;
      end else begin
        i = exp_idx_q.pop_front();
        chk("load_idx", bus.cur_idx, i);
        chk("load_period", bus.gen_period, sh_period[i]);
        exp_edges = (sh_count[i] == 0) ? 1 : int'(sh_count[i]);
        p         = (sh_period[i] == 0) ? 1 : int'(sh_period[i]);
        exp_cyc   = (2 * exp_edges - 1) * p;
      end
      edges      = 0;
      run_cyc    = 0;
      in_run     = 1'b1;
      after_load = 1'b1;
      prev_gen   = 1'b0;
    end else if (bus.busy) begin
      run_cyc++;
      if (gen_q && !prev_gen) edges++;
      prev_gen = gen_q;
    end else begin
      if (in_run) close_entry();
      in_run   = 1'b0;
      prev_gen = 1'b0;
    end

    if (bus.done) begin
      n_cmp++;
      if (exp_done == 0 || bus.busy) begin
        n_err++;
        $display("FAIL unexpected_done: done=1 busy=%0d pending=%0d required pending>0 busy=0",
                 bus.busy, exp_done);
      end else begin
        exp_done--;
      end
    end
  end

  task automatic wr(input int a, input int per, input int cnt);
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = AW'(a);
    bus.cfg_period = 32'(per);
    bus.cfg_count  = CW'(cnt);
    @(posedge clk);
    sh_period[a] = per;
    sh_count[a]  = cnt;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic play(input int len, input bit lp, input int npush, input bit want_done);
    int eff;
    eff = (len > DEPTH) ? DEPTH : len;
    for (int k = 0; k < npush; k++) exp_idx_q.push_back(k % eff);
    if (want_done) exp_done++;
    bus.seq_len = (AW + 1)'(len);
    bus.loop_en = lp;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_latency_busy", bus.busy, 1);
    chk("start_latency_gen_rst", bus.gen_rst, 1);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (bus.busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (bus.busy) begin
      n_err++;
      $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", budget);
    end
  endtask

  task automatic wait_drained(input int budget);
    int c;
    c = 0;
    while (exp_idx_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("drain_timeout", exp_idx_q.size(), 0);
  endtask

  task automatic wait_run_idx(input int idx, input int budget);
    int c;
    c = 0;
    while (!(bus.busy && !bus.gen_rst && bus.cur_idx == idx) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("reach_run_idx", bus.cur_idx, idx);
  endtask

  task automatic finish_oneshot();
    wait_idle(2000);
    repeat (2) @(negedge clk);
    chk("done_pulse_seen", exp_done, 0);
    chk("entries_consumed", exp_idx_q.size(), 0);
    chk("idle_gen_rst", bus.gen_rst, 1);
    chk("idle_busy", bus.busy, 0);
  endtask

  task automatic stop_loop();
    int saved;
    @(negedge clk);
    saved    = bus.cur_idx;
    abort    = 1'b1;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("stop_busy", bus.busy, 0);
    chk("stop_gen_rst", bus.gen_rst, 1);
    chk("stop_cur_idx_held", bus.cur_idx, saved);
    chk("stop_no_done", bus.done, 0);
    repeat (3) @(negedge clk);
    chk("stop_stays_idle", bus.busy, 0);
    abort = 1'b0;
  endtask

  initial begin : wdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int len, n;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_period = '0; bus.cfg_count = '0;
    bus.seq_len = '0; bus.loop_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.gen_out = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_gen_rst", bus.gen_rst, 1);
    chk("rst_gen_period", bus.gen_period, 0);
    chk("rst_cur_idx", bus.cur_idx, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    @(negedge clk);

    // single entry
    wr(0, 4, 2);
    play(1, 1'b0, 1, 1'b1);
    chk("first_load_period", bus.gen_period, 4);
    finish_oneshot();

    // three-entry one-shot
    wr(0, 4, 1); wr(1, 10, 3); wr(2, 2, 2);
    play(3, 1'b0, 3, 1'b1);
    finish_oneshot();

    // looping: three full passes plus the wrap into a fourth, then stop
    play(3, 1'b1, 10, 1'b0);
    wait_drained(3000);
    stop_loop();

    // count 0 behaves as count 1
    wr(0, 6, 0);
    play(1, 1'b0, 1, 1'b1);
    finish_oneshot();

    // zero length start, and start+stop together, are ignored
    bus.seq_len = '0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("len0_busy", bus.busy, 0);
      @(negedge clk);
    end
    bus.seq_len = 4'd1; bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("start_stop_busy", bus.busy, 0);
      @(negedge clk);
    end

    // rewrite entry1 during entry0, then reset during entry1
    wr(0, 3, 2); wr(1, 5, 3); wr(2, 2, 1);
    play(3, 1'b0, 3, 1'b0);
    wait_run_idx(0, 10);
    wr(1, 7, 3);
    wait_run_idx(1, 200);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_gen_rst", bus.gen_rst, 1);
    chk("midrst_gen_period", bus.gen_period, 0);
    chk("midrst_cur_idx", bus.cur_idx, 0);
    chk("midrst_done", bus.done, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b0;

    // randomized one-shot runs, some with seq_len beyond the table depth
    for (int it = 0; it < 15; it++) begin
      for (int a = 0; a < DEPTH; a++) wr(a, int'($urandom_range(1, 5)), int'($urandom_range(0, 4)));
      len = int'($urandom_range(1, 15));
      play(len, 1'b0, (len > DEPTH) ? DEPTH : len, 1'b1);
      n = int'($urandom_range(0, 6));
      repeat (n) @(negedge clk);
      if (bus.busy) begin
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      finish_oneshot();
    end

    // randomized loop run
    for (int a = 0; a < DEPTH; a++) wr(a, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
    len = int'($urandom_range(1, 8));
    play(len, 1'b1, 2 * len + 1, 1'b0);
    wait_drained(3000);
    stop_loop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
